// File: rtl/varredura_matriz_pkg.sv
// Shared types and constants for the 7x5 LED matrix row scanner.
package varredura_matriz_pkg;

  localparam int NUM_LINHAS    = 7;
  localparam int NUM_COLUNAS   = 5;
  localparam int LARG_CONTADOR = 3;
  localparam int LARG_QUADRO   = 3;

  typedef enum logic [1:0] {
    OCIOSO,
    CARREGA,
    EXIBE,
    APAGA
  } estado_t;

  function automatic int maior(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [NUM_LINHAS-1:0] linha_onehot(input logic [LARG_CONTADOR-1:0] idx);
    linha_onehot = '0;
    if (int'(idx) < NUM_LINHAS) linha_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/varredura_matriz_contador_tempo.sv
// Loadable down-counter; terminal is high while the count sits at zero.
module contador_tempo #(
  parameter int LARGURA = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carrega,
  input  logic [LARGURA-1:0] valor,
  output logic               terminal
);

  logic [LARGURA-1:0] cont;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cont <= '0;
    else if (carrega)
      cont <= valor;
    else if (cont != '0)
      cont <= cont - LARGURA'(1);
  end

  assign terminal = (cont == '0);

endmodule

// File: rtl/varredura_matriz.sv
// Row-multiplexed LED matrix scanner: lights one row at a time with blanking
// between rows and advances the displayed frame after a number of full scans.
module varredura_matriz
  import varredura_matriz_pkg::*;
#(
  parameter int DIV_CICLOS   = 1000,
  parameter int APAGA_CICLOS = 2,
  parameter int QUADROS      = 6,
  parameter int VARREDURAS   = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     habilita,
  input  logic [NUM_COLUNAS-1:0]   colunas_in,
  output logic [LARG_CONTADOR-1:0] contador,
  output logic [LARG_QUADRO-1:0]   quadro,
  output logic [NUM_LINHAS-1:0]    linhas,
  output logic [NUM_COLUNAS-1:0]   colunas,
  output logic                     fim_quadro
);

  localparam int LARG_TEMPO  = $clog2(maior(DIV_CICLOS, APAGA_CICLOS) + 1);
  localparam int LARG_VARRED = (VARREDURAS > 1) ? $clog2(VARREDURAS) : 1;

  estado_t                 estado, estado_prox;
  logic                    carrega_tempo;
  logic [LARG_TEMPO-1:0]   valor_tempo;
  logic                    tempo_fim;
  logic                    acende_linha;
  logic                    apaga_linha;
  logic                    avanca_linha;
  logic [LARG_VARRED-1:0]  varreduras;

  // Timer is loaded with N-1 so the interval ends on the cycle it reads zero.
  contador_tempo #(
    .LARGURA(LARG_TEMPO)
  ) u_tempo (
    .clk      (clk),
    .rst_n    (rst_n),
    .carrega  (carrega_tempo),
    .valor    (valor_tempo),
    .terminal (tempo_fim)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      estado <= OCIOSO;
    else
      estado <= estado_prox;
  end

  always_comb begin
    estado_prox   = estado;
    carrega_tempo = 1'b0;
    valor_tempo   = '0;
    acende_linha  = 1'b0;
    apaga_linha   = 1'b0;
    avanca_linha  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilita) estado_prox = CARREGA;
      end
      CARREGA: begin
        estado_prox   = EXIBE;
        carrega_tempo = 1'b1;
        valor_tempo   = LARG_TEMPO'(DIV_CICLOS - 1);
        acende_linha  = 1'b1;
      end
      EXIBE: begin
        if (tempo_fim) begin
          estado_prox   = APAGA;
          carrega_tempo = 1'b1;
          valor_tempo   = LARG_TEMPO'(APAGA_CICLOS - 1);
          apaga_linha   = 1'b1;
        end
      end
      APAGA: begin
        if (tempo_fim) begin
          avanca_linha = 1'b1;
          estado_prox  = habilita ? CARREGA : OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      linhas  <= '0;
      colunas <= '0;
    end else if (acende_linha) begin
      linhas  <= linha_onehot(contador);
      colunas <= colunas_in;
    end else if (apaga_linha) begin
      linhas  <= '0;
      colunas <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      contador   <= '0;
      quadro     <= '0;
      varreduras <= '0;
      fim_quadro <= 1'b0;
    end else begin
      fim_quadro <= 1'b0;
      if (avanca_linha) begin
        if (contador == LARG_CONTADOR'(NUM_LINHAS - 1)) begin
          contador <= '0;
          if (varreduras == LARG_VARRED'(VARREDURAS - 1)) begin
            varreduras <= '0;
            fim_quadro <= 1'b1;
            quadro     <= (quadro == LARG_QUADRO'(QUADROS - 1)) ? '0 : quadro + LARG_QUADRO'(1);
          end else begin
            varreduras <= varreduras + LARG_VARRED'(1);
          end
        end else begin
          contador <= contador + LARG_CONTADOR'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_varredura_matriz.sv
// Directed bench for varredura_matriz with short row/blank/scan timing.
module tb_varredura_matriz;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       habilita;
  logic [4:0] colunas_in;
  logic [2:0] contador;
  logic [2:0] quadro;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic       fim_quadro;

  int total = 0;
  int bad   = 0;
  int ciclo = 0;

  varredura_matriz #(
    .DIV_CICLOS   (4),
    .APAGA_CICLOS (2),
    .QUADROS      (2),
    .VARREDURAS   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .habilita   (habilita),
    .colunas_in (colunas_in),
    .contador   (contador),
    .quadro     (quadro),
    .linhas     (linhas),
    .colunas    (colunas),
    .fim_quadro (fim_quadro)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s @ciclo %0d: got %0h expected %0h", tag, ciclo, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ciclo++;
  endtask

  task automatic ate(input int n);
    while (ciclo < n) tick();
  endtask

  task automatic zeros(input string tag);
    verifica({tag, "_linhas"}, linhas, 0);
    verifica({tag, "_colunas"}, colunas, 0);
    verifica({tag, "_contador"}, contador, 0);
    verifica({tag, "_quadro"}, quadro, 0);
    verifica({tag, "_fim"}, fim_quadro, 0);
  endtask

  initial begin
    int pulsos;
    logic [4:0] ci_ant;
    logic [6:0] lin_ant;
    logic [4:0] col_ant;
    logic [2:0] cnt_ant;
    logic [4:0] col_esp;

    rst_n      = 1'b0;
    habilita   = 1'b0;
    colunas_in = 5'b10101;
    tick();
    tick();
    zeros("reset");

    // edge E1: CARREGA, E2..E5: row 0 lit, E6..E7: blank, E8: next row
    ciclo    = 0;
    rst_n    = 1'b1;
    habilita = 1'b1;
    tick();
    verifica("carrega_escuro", linhas, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      verifica("linha0", linhas, 7'b0000001);
      verifica("colunas0", colunas, 5'b10101);
      if (i == 0) colunas_in = 5'b01010;
    end
    tick();
    verifica("apaga1_linhas", linhas, 0);
    verifica("apaga1_colunas", colunas, 0);
    verifica("apaga1_contador", contador, 0);
    tick();
    verifica("apaga2_linhas", linhas, 0);
    verifica("apaga2_contador", contador, 0);
    tick();
    verifica("contador1", contador, 1);
    verifica("carrega1_linhas", linhas, 0);

    // frame advances at E99 (14 slots of 7 cycles after E1)
    ate(98);
    verifica("antes_q1_quadro", quadro, 0);
    verifica("antes_q1_fim", fim_quadro, 0);
    tick();
    verifica("q1_quadro", quadro, 1);
    verifica("q1_fim", fim_quadro, 1);
    verifica("q1_contador", contador, 0);
    pulsos = 0;
    tick();
    verifica("q1_fim_unico", fim_quadro, 0);
    while (ciclo < 196) begin
      tick();
      if (fim_quadro) pulsos++;
    end
    verifica("sem_pulso_extra", pulsos, 0);
    verifica("antes_q0_quadro", quadro, 1);
    tick();
    verifica("q0_quadro", quadro, 0);
    verifica("q0_fim", fim_quadro, 1);

    // row 3 lit from E219; drop enable mid-row
    ate(219);
    verifica("linha3", linhas, 7'b0001000);
    tick();
    habilita = 1'b0;
    ate(224);
    verifica("linha3_apagada", linhas, 0);
    verifica("linha3_contador", contador, 3);
    tick();
    verifica("ocioso_contador", contador, 4);
    verifica("ocioso_linhas", linhas, 0);
    ate(227);
    verifica("ocioso_retido", contador, 4);
    verifica("ocioso_escuro", linhas, 0);
    habilita = 1'b1;
    tick();
    verifica("retoma_carrega", linhas, 0);
    tick();
    verifica("retoma_linha4", linhas, 7'b0010000);

    // frame 1 begins at E298; row 5 lit from E334
    ate(298);
    verifica("q1b_quadro", quadro, 1);
    verifica("q1b_fim", fim_quadro, 1);
    ate(335);
    verifica("linha5", linhas, 7'b0100000);
    verifica("linha5_contador", contador, 5);
    rst_n = 1'b0;
    tick();
    zeros("reset_exibe");

    rst_n = 1'b1;
    ci_ant = colunas_in;
    for (int i = 0; i < 300; i++) begin
      lin_ant = linhas;
      col_ant = colunas;
      cnt_ant = contador;
      ci_ant  = colunas_in;
      tick();
      verifica("onehot", ($countones(linhas) <= 1), 1);
      if (linhas != 0) verifica("linha_contador", linhas, 7'b0000001 << contador);
      if (linhas == 0)       col_esp = 5'b00000;
      else if (lin_ant == 0) col_esp = ci_ant;
      else                   col_esp = col_ant;
      verifica("colunas_rand", colunas, col_esp);
      if (contador != cnt_ant) verifica("contador_escuro", {lin_ant, linhas}, 0);
      colunas_in = 5'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
